// File: rtl/lfsr_prescaler_gen.sv
// -----------------------------------------------------------------------------
// lfsr_prescaler_gen
//
// Fully synchronous prescaler + Fibonacci LFSR noise generator.
//   - A DIV_W-bit free-running counter produces a registered power-of-two tick.
//   - A LFSR_W-bit Fibonacci LFSR steps from one of four selectable sources:
//       mode 0 = prescaler tick, 1 = step_in level, 2 = step_in rising edge,
//       mode 3 = every cycle. All sources are gated by en.
//   - load has priority over stepping and works even when en=0. A zero seed is
//     rejected: the LFSR falls back to SEED and lock_err pulses for one cycle.
//
// Optional feature (compile-time macro LFSR_PERIOD_CNT_EN):
//   Adds a reference register (captured on load/reset) and a saturating step
//   counter; period_done pulses when a step returns the LFSR to the reference.
//   Without the macro period_done is tied low; the port list is unchanged.
//
// Ports
//   clk          in   1              rising-edge clock
//   rst_n        in   1              asynchronous active-low reset
//   en           in   1              enable for prescaler and stepping
//   mode         in   2              step source select
//   div_sel      in   $clog2(DIV_W)  prescaler stage select (clamped to DIV_W-1)
//   step_in      in   1              external step strobe/level
//   load         in   1              load seed into LFSR
//   seed         in   LFSR_W         value loaded on load
//   cnt_out      out  DIV_W          prescaler count
//   lfsr_out     out  LFSR_W         LFSR state
//   bit_out      out  1              LFSR MSB (combinational view)
//   tick         out  1              one-cycle registered prescaler pulse
//   lock_err     out  1              one-cycle pulse after a zero seed was rejected
//   period_done  out  1              one-cycle pulse when LFSR returns to reference
// -----------------------------------------------------------------------------
module lfsr_prescaler_gen #(
    parameter int                 DIV_W     = 16,
    parameter int                 LFSR_W    = 8,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8,
    parameter logic [LFSR_W-1:0]  SEED      = 8'h01
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [$clog2(DIV_W)-1:0]  div_sel,
    input  logic                      step_in,
    input  logic                      load,
    input  logic [LFSR_W-1:0]         seed,
    output logic [DIV_W-1:0]          cnt_out,
    output logic [LFSR_W-1:0]         lfsr_out,
    output logic                      bit_out,
    output logic                      tick,
    output logic                      lock_err,
    output logic                      period_done
);

    typedef enum logic [1:0] {
        MODE_TICK  = 2'd0,
        MODE_LEVEL = 2'd1,
        MODE_RISE  = 2'd2,
        MODE_FREE  = 2'd3
    } mode_e;

    logic [DIV_W-1:0]  tick_mask;
    logic              step_in_d;
    logic              step_req;
    logic              step;
    logic              seed_zero;
    logic [LFSR_W-1:0] load_val;
    logic [LFSR_W-1:0] lfsr_next;

    // Low-order mask covering bits [s:0]. Any div_sel at or above DIV_W-1
    // simply sets every bit, which is exactly the clamp to the top stage.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path can leave it unassigned and infer a latch.
        tick_mask = '0;
        for (int i = 0; i < DIV_W; i++) begin
            tick_mask[i] = (i <= int'(div_sel));
        end
    end

    // Step source selection; the mode input is used directly each cycle so a
    // mode change applies immediately and nothing is queued.
    always_comb begin
        step_req = 1'b0;
        case (mode_e'(mode))
            MODE_TICK:  step_req = tick;
            MODE_LEVEL: step_req = step_in;
            MODE_RISE:  step_req = step_in & ~step_in_d;
            MODE_FREE:  step_req = 1'b1;
            default:    step_req = 1'b0;
        endcase
    end

    assign step      = en & step_req;
    assign seed_zero = (seed == '0);
    assign load_val  = seed_zero ? SEED : seed;
    assign lfsr_next = {lfsr_out[LFSR_W-2:0], ^(lfsr_out & LFSR_TAPS)};
    assign bit_out   = lfsr_out[LFSR_W-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_out   <= '0;
            tick      <= 1'b0;
            step_in_d <= 1'b0;
            lfsr_out  <= SEED;
            lock_err  <= 1'b0;
        end else begin
            // Edge detector history runs even while disabled so re-enabling
            // with step_in already high does not fake a rising edge.
            step_in_d <= step_in;
            tick      <= en & ((cnt_out & tick_mask) == tick_mask);
            if (en) begin
                cnt_out <= cnt_out + DIV_W'(1);
            end
            lock_err <= load & seed_zero;
            // load wins; a step in the same cycle is dropped.
            if (load) begin
                lfsr_out <= load_val;
            end else if (step) begin
                lfsr_out <= lfsr_next;
            end
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [LFSR_W-1:0] ref_val;
    logic [LFSR_W-1:0] step_cnt;

    // ref_val holds the value the sequence started from; step_cnt counts
    // accepted steps since then and saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_val     <= SEED;
            step_cnt    <= '0;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            if (load) begin
                ref_val  <= load_val;
                step_cnt <= '0;
            end else if (step) begin
                if (lfsr_next == ref_val) begin
                    period_done <= 1'b1;
                    step_cnt    <= '0;
                end else if (step_cnt != '1) begin
                    step_cnt <= step_cnt + LFSR_W'(1);
                end
            end
        end
    end
`else
    assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prescaler_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prescaler_gen
//
// Directed bench for lfsr_prescaler_gen (LFSR_W=8, TAPS=8'hB8, SEED=8'h01).
// A 16-bit-divider instance is the main DUT; a 12-bit-divider instance shares
// the same inputs to show the div_sel clamp. A vector table covers single-cycle
// behaviour; hand-written sequences cover tick timing, full period, edge/level
// stepping, the period_done feature and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_lfsr_prescaler_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  div_sel;
    logic        step_in;
    logic        load;
    logic [7:0]  seed;

    logic [15:0] cnt_out;
    logic [7:0]  lfsr_out;
    logic        bit_out;
    logic        tick;
    logic        lock_err;
    logic        period_done;

    logic [11:0] cnt_12;
    logic [7:0]  lfsr_12;
    logic        bit_12;
    logic        tick_12;
    logic        lock_12;
    logic        period_12;

    int total = 0;
    int bad   = 0;

    lfsr_prescaler_gen #(
        .DIV_W(16), .LFSR_W(8), .LFSR_TAPS(8'hB8), .SEED(8'h01)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div_sel(div_sel),
        .step_in(step_in), .load(load), .seed(seed),
        .cnt_out(cnt_out), .lfsr_out(lfsr_out), .bit_out(bit_out),
        .tick(tick), .lock_err(lock_err), .period_done(period_done)
    );

    lfsr_prescaler_gen #(
        .DIV_W(12), .LFSR_W(8), .LFSR_TAPS(8'hB8), .SEED(8'h01)
    ) u_dut12 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div_sel(div_sel),
        .step_in(step_in), .load(load), .seed(seed),
        .cnt_out(cnt_12), .lfsr_out(lfsr_12), .bit_out(bit_12),
        .tick(tick_12), .lock_err(lock_12), .period_done(period_12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        step_in;
        logic        load;
        logic [7:0]  seed;
        logic [7:0]  exp_lfsr;
        logic [15:0] exp_cnt;
        logic        exp_tick;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 2'd0;
        div_sel = 4'd15;
        step_in = 1'b0;
        load    = 1'b0;
        seed    = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          steps;
        int          changes;
        int          first_16;
        int          first_12;
        logic [7:0]  prev;
        logic        exp_pd;

        // en mode stp ld seed | lfsr cnt tick lock
        vecs[0]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h02, 16'd1,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h04, 16'd2,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h08, 16'd3,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h11, 16'd4,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 8'h00, 8'h01, 16'd5,  1'b0, 1'b1};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h02, 16'd6,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 8'h5A, 8'h5A, 16'd7,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'hB4, 16'd8,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'hB4, 16'd8,  1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 1'b1, 8'h23, 8'h23, 16'd8,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h23, 16'd8,  1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h23, 16'd9,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 8'h47, 16'd10, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 8'h8E, 16'd11, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h8E, 16'd12, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h8E, 16'd13, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h1C, 16'd14, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h1C, 16'd15, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h1C, 16'd16, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h1C, 16'd16, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 8'h1C, 16'd16, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h00, 8'h1C, 16'd17, 1'b0, 1'b0};

        // ---- reset state ----
        do_reset();
        check("rst cnt",    32'(cnt_out),     32'h0);
        check("rst lfsr",   32'(lfsr_out),    32'h01);
        check("rst bit",    32'(bit_out),     32'h0);
        check("rst tick",   32'(tick),        32'h0);
        check("rst lock",   32'(lock_err),    32'h0);
        check("rst period", 32'(period_done), 32'h0);

        // ---- vector table ----
        for (int i = 0; i < 22; i++) begin
            en      = vecs[i].en;
            mode    = vecs[i].mode;
            step_in = vecs[i].step_in;
            load    = vecs[i].load;
            seed    = vecs[i].seed;
            cycle();
            check($sformatf("vec%0d lfsr", i), 32'(lfsr_out), 32'(vecs[i].exp_lfsr));
            check($sformatf("vec%0d bit",  i), 32'(bit_out),  32'(vecs[i].exp_lfsr[7]));
            check($sformatf("vec%0d cnt",  i), 32'(cnt_out),  32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d tick", i), 32'(tick),     32'(vecs[i].exp_tick));
            check($sformatf("vec%0d lock", i), 32'(lock_err), 32'(vecs[i].exp_lock));
        end
        load = 1'b0;

        // ---- full period from SEED in free-running mode ----
        do_reset();
        en   = 1'b1;
        mode = 2'd3;
        cycle();
        check("period first step", 32'(lfsr_out), 32'h02);
        steps = 1;
        while (lfsr_out != 8'h01 && steps < 300) begin
            cycle();
            steps++;
        end
        check("period length", 32'(steps), 32'd255);

        // ---- tick timing, div_sel=2, mode 0 ----
        do_reset();
        en      = 1'b1;
        mode    = 2'd0;
        div_sel = 4'd2;
        prev    = lfsr_out;
        for (int n = 1; n <= 26; n++) begin
            cycle();
            check($sformatf("tick n=%0d", n), 32'(tick), 32'((n % 8) == 0));
            check($sformatf("lfsr move n=%0d", n), 32'(lfsr_out != prev),
                  32'(((n % 8) == 1) && (n > 1)));
            prev = lfsr_out;
        end
        check("tick-driven lfsr", 32'(lfsr_out), 32'h08);

        // ---- div_sel=15: no clamp on 16-bit divider, clamp to 11 on 12-bit ----
        do_reset();
        en       = 1'b1;
        mode     = 2'd1;
        div_sel  = 4'd15;
        first_16 = 0;
        first_12 = 0;
        for (int n = 1; n <= 65540; n++) begin
            cycle();
            if (tick && first_16 == 0)    first_16 = n;
            if (tick_12 && first_12 == 0) first_12 = n;
        end
        check("first tick div16", 32'(first_16), 32'd65536);
        check("first tick div12", 32'(first_12), 32'd4096);

        // ---- step_in held high: edge mode vs level mode ----
        do_reset();
        en      = 1'b1;
        mode    = 2'd2;
        step_in = 1'b1;
        changes = 0;
        repeat (10) begin
            prev = lfsr_out;
            cycle();
            if (lfsr_out != prev) changes++;
        end
        check("rise mode steps", 32'(changes), 32'd1);
        step_in = 1'b0;
        cycle();
        mode    = 2'd1;
        step_in = 1'b1;
        changes = 0;
        repeat (10) begin
            prev = lfsr_out;
            cycle();
            if (lfsr_out != prev) changes++;
        end
        check("level mode steps", 32'(changes), 32'd10);
        step_in = 1'b0;

        // ---- period_done after load 0x37 ----
        do_reset();
        en   = 1'b1;
        mode = 2'd3;
        load = 1'b1;
        seed = 8'h37;
        cycle();
        load = 1'b0;
        check("load 37", 32'(lfsr_out), 32'h37);
        for (int k = 1; k <= 520; k++) begin
            cycle();
`ifdef LFSR_PERIOD_CNT_EN
            exp_pd = (k == 255) || (k == 510);
`else
            exp_pd = 1'b0;
`endif
            check($sformatf("period_done k=%0d", k), 32'(period_done), 32'(exp_pd));
            if (k == 255) check("lfsr back to 37", 32'(lfsr_out), 32'h37);
        end

        // ---- asynchronous reset mid-run ----
        do_reset();
        en      = 1'b1;
        mode    = 2'd3;
        div_sel = 4'd0;
        repeat (4660) cycle();
        check("pre-reset cnt",  32'(cnt_out), 32'h1234);
        check("pre-reset tick", 32'(tick),    32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async cnt",    32'(cnt_out),     32'h0);
        check("async lfsr",   32'(lfsr_out),    32'h01);
        check("async bit",    32'(bit_out),     32'h0);
        check("async tick",   32'(tick),        32'h0);
        check("async lock",   32'(lock_err),    32'h0);
        check("async period", 32'(period_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b1;
        seed  = 8'h00;
        cycle();
        load  = 1'b0;
        check("pre-reset lock", 32'(lock_err), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async lock clear", 32'(lock_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
